// File: rtl/sd_block_collector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sd_block_collector: SD block framing FSM with first-word-fall-through FIFO |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module sd_block_collector #(
    parameter int DEPTH       = 16,
    parameter int BLOCK_BYTES = 512
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     block_start,
    input  logic [7:0]               byte_in,
    input  logic                     byte_strobe,
    output logic [7:0]               data_out,
    output logic                     data_valid,
    input  logic                     data_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [9:0]               byte_count,
    output logic                     block_done,
    output logic                     busy,
    output logic                     overflow,
    output logic                     token_error
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);
    localparam logic [9:0]  LAST_IDX   = 10'(BLOCK_BYTES - 1);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HUNT = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_CRC  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    logic [2:0]    r_state;
    logic [2:0]    w_state_next;
    logic          r_crc_second;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;

    logic w_push_req;
    logic w_push_ok;
    logic w_pop;
    logic w_full;
    logic w_drop;
    logic w_token_hit;

    // block_start outranks every state transition, including a same-cycle strobe
    always_comb begin
        w_state_next = r_state;
        w_push_req   = 1'b0;
        w_token_hit  = 1'b0;
        if (block_start) begin
            w_state_next = ST_HUNT;
        end else begin
            case (r_state)
                ST_IDLE: w_state_next = ST_IDLE;
                ST_HUNT: begin
                    if (byte_strobe) begin
                        if (byte_in == 8'hFE) begin
                            w_state_next = ST_DATA;
                        end else if (byte_in[7:4] == 4'b0000) begin
                            w_state_next = ST_IDLE;
                            w_token_hit  = 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (byte_strobe) begin
                        w_push_req = 1'b1;
                        if (byte_count == LAST_IDX) begin
                            w_state_next = ST_CRC;
                        end
                    end
                end
                ST_CRC: begin
                    if (byte_strobe && r_crc_second) begin
                        w_state_next = ST_DONE;
                    end
                end
                ST_DONE: w_state_next = ST_IDLE;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    assign data_valid = (level != '0);
    assign data_out   = r_mem[r_rptr];
    assign w_full     = (level == FULL_LEVEL);
    assign w_pop      = data_valid && data_ready;
    // A full FIFO still accepts a byte when the head leaves in the same cycle
    assign w_push_ok  = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_crc_second <= 1'b0;
            busy         <= 1'b0;
            block_done   <= 1'b0;
            byte_count   <= 10'd0;
            overflow     <= 1'b0;
            token_error  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            busy       <= (w_state_next != ST_IDLE);
            block_done <= (w_state_next == ST_DONE);
            if (block_start) begin
                byte_count   <= 10'd0;
                overflow     <= 1'b0;
                token_error  <= 1'b0;
                r_crc_second <= 1'b0;
            end else begin
                if (w_push_req) begin
                    byte_count <= byte_count + 10'd1;
                end
                if (w_drop) begin
                    overflow <= 1'b1;
                end
                if (w_token_hit) begin
                    token_error <= 1'b1;
                end
                if (r_state == ST_CRC && byte_strobe) begin
                    r_crc_second <= ~r_crc_second;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= byte_in;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sd_block_collector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sd_block_collector: directed self-checking bench for sd_block_collector |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module tb_sd_block_collector;

    logic       clock;
    logic       reset;
    logic       block_start;
    logic [7:0] byte_in;
    logic       byte_strobe;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic [4:0] level;
    logic [9:0] byte_count;
    logic       block_done;
    logic       busy;
    logic       overflow;
    logic       token_error;

    int         n_cmp = 0;
    int         n_err = 0;
    int         done_cnt = 0;
    logic       mon_en = 1'b0;
    logic [7:0] got [$];

    sd_block_collector #(.DEPTH(16), .BLOCK_BYTES(512)) dut (
        .clock       (clock),
        .reset       (reset),
        .block_start (block_start),
        .byte_in     (byte_in),
        .byte_strobe (byte_strobe),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .level       (level),
        .byte_count  (byte_count),
        .block_done  (block_done),
        .busy        (busy),
        .overflow    (overflow),
        .token_error (token_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Bytes leaving the FIFO are captured mid-cycle, ahead of the popping edge
    always @(negedge clock) begin
        if (mon_en && data_valid && data_ready) got.push_back(data_out);
        if (block_done) done_cnt++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        block_start = 1'b1;
        tick();
        block_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        byte_in     = b;
        byte_strobe = 1'b1;
        tick();
        byte_strobe = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL reset_level: got %0d expected 0", level); end
        n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", data_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (byte_count !== 10'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", byte_count); end
        n_cmp++; if ({block_done, overflow, token_error} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b expected 000", {block_done, overflow, token_error}); end
    endtask

    task automatic test_normal_block();
        int bad;
        int d0;
        do_reset();
        got.delete();
        mon_en     = 1'b1;
        data_ready = 1'b1;
        d0         = done_cnt;
        pulse_start();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL normal_busy: got %b expected 1", busy); end
        send(8'hFF);
        send(8'hFF);
        send(8'hFE);
        for (int i = 0; i < 512; i++) send(8'(i));
        n_cmp++; if (byte_count !== 10'd512) begin n_err++; $display("FAIL normal_count: got %0d expected 512", byte_count); end
        send(8'hAA);
        n_cmp++; if (block_done !== 1'b0) begin n_err++; $display("FAIL normal_done_early: got %b expected 0", block_done); end
        send(8'h55);
        n_cmp++; if (block_done !== 1'b1) begin n_err++; $display("FAIL normal_done: got %b expected 1", block_done); end
        tick();
        n_cmp++; if ({block_done, busy} !== 2'b00) begin n_err++; $display("FAIL normal_after_done: got %b expected 00", {block_done, busy}); end
        send(8'h77);
        repeat (4) tick();
        n_cmp++; if (byte_count !== 10'd512) begin n_err++; $display("FAIL normal_count_hold: got %0d expected 512", byte_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL normal_overflow: got %b expected 0", overflow); end
        n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL normal_done_pulses: got %0d expected 1", done_cnt - d0); end
        n_cmp++; if (got.size() !== 512) begin n_err++; $display("FAIL normal_out_size: got %0d expected 512", got.size()); end
        bad = -1;
        for (int i = 0; i < got.size() && i < 512; i++)
            if (bad < 0 && got[i] !== 8'(i)) bad = i;
        n_cmp++; if (bad >= 0) begin n_err++; $display("FAIL normal_order: index %0d got %h expected %h", bad, got[bad], 8'(bad)); end
        mon_en = 1'b0;
    endtask

    task automatic test_backpressure();
        int bad;
        do_reset();
        data_ready = 1'b0;
        pulse_start();
        send(8'hFE);
        for (int i = 0; i < 20; i++) send(8'h10 + 8'(i));
        n_cmp++; if (level !== 5'd16) begin n_err++; $display("FAIL bp_level: got %0d expected 16", level); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL bp_overflow: got %b expected 1", overflow); end
        n_cmp++; if (byte_count !== 10'd20) begin n_err++; $display("FAIL bp_count: got %0d expected 20", byte_count); end
        n_cmp++; if (data_out !== 8'h10) begin n_err++; $display("FAIL bp_head: got %h expected 10", data_out); end
        got.delete();
        mon_en     = 1'b1;
        data_ready = 1'b1;
        repeat (20) tick();
        mon_en = 1'b0;
        n_cmp++; if (got.size() !== 16) begin n_err++; $display("FAIL bp_out_size: got %0d expected 16", got.size()); end
        bad = -1;
        for (int i = 0; i < got.size() && i < 16; i++)
            if (bad < 0 && got[i] !== 8'h10 + 8'(i)) bad = i;
        n_cmp++; if (bad >= 0) begin n_err++; $display("FAIL bp_order: index %0d got %h expected %h", bad, got[bad], 8'h10 + 8'(bad)); end
        n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL bp_drained: got %0d expected 0", level); end
    endtask

    task automatic test_full_push_pop();
        int bad;
        do_reset();
        data_ready = 1'b0;
        pulse_start();
        send(8'hFE);
        for (int i = 0; i < 16; i++) send(8'h40 + 8'(i));
        n_cmp++; if (level !== 5'd16) begin n_err++; $display("FAIL full_level: got %0d expected 16", level); end
        got.delete();
        mon_en     = 1'b1;
        data_ready = 1'b1;
        send(8'h99);
        data_ready = 1'b0;
        n_cmp++; if (level !== 5'd16) begin n_err++; $display("FAIL full_pp_level: got %0d expected 16", level); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL full_pp_overflow: got %b expected 0", overflow); end
        n_cmp++; if (data_out !== 8'h41) begin n_err++; $display("FAIL full_pp_head: got %h expected 41", data_out); end
        data_ready = 1'b1;
        repeat (20) tick();
        mon_en = 1'b0;
        n_cmp++; if (got.size() !== 17) begin n_err++; $display("FAIL full_out_size: got %0d expected 17", got.size()); end
        bad = -1;
        for (int i = 0; i < got.size() && i < 16; i++)
            if (bad < 0 && got[i] !== 8'h40 + 8'(i)) bad = i;
        n_cmp++; if (bad >= 0) begin n_err++; $display("FAIL full_order: index %0d got %h expected %h", bad, got[bad], 8'h40 + 8'(bad)); end
        n_cmp++; if (got.size() > 16 && got[16] !== 8'h99) begin n_err++; $display("FAIL full_last: got %h expected 99", got[16]); end
    endtask

    task automatic test_error_token();
        int d0;
        do_reset();
        data_ready = 1'b1;
        d0 = done_cnt;
        pulse_start();
        send(8'hFF);
        send(8'h05);
        n_cmp++; if (token_error !== 1'b1) begin n_err++; $display("FAIL tok_flag: got %b expected 1", token_error); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL tok_busy: got %b expected 0", busy); end
        n_cmp++; if ({data_valid, level} !== 6'd0) begin n_err++; $display("FAIL tok_fifo: got valid %b level %0d expected empty", data_valid, level); end
        send(8'hFE);
        send(8'h11);
        n_cmp++; if ({busy, data_valid} !== 2'b00) begin n_err++; $display("FAIL tok_idle_strobe: got %b expected 00", {busy, data_valid}); end
        n_cmp++; if (done_cnt !== d0) begin n_err++; $display("FAIL tok_no_done: got %0d pulses expected 0", done_cnt - d0); end
        pulse_start();
        n_cmp++; if ({busy, token_error} !== 2'b10) begin n_err++; $display("FAIL tok_restart: got %b expected 10", {busy, token_error}); end
    endtask

    task automatic test_restart();
        do_reset();
        got.delete();
        mon_en     = 1'b1;
        data_ready = 1'b1;
        pulse_start();
        send(8'hFE);
        for (int i = 0; i < 100; i++) send(8'(i));
        n_cmp++; if (byte_count !== 10'd100) begin n_err++; $display("FAIL rs_count100: got %0d expected 100", byte_count); end
        pulse_start();
        n_cmp++; if ({busy, byte_count} !== {1'b1, 10'd0}) begin n_err++; $display("FAIL rs_state: got busy %b count %0d expected 1/0", busy, byte_count); end
        send(8'h3C);
        n_cmp++; if (byte_count !== 10'd0) begin n_err++; $display("FAIL rs_hunt: got %0d expected 0", byte_count); end
        send(8'hFE);
        send(8'hC3);
        n_cmp++; if (byte_count !== 10'd1) begin n_err++; $display("FAIL rs_count1: got %0d expected 1", byte_count); end
        repeat (4) tick();
        mon_en = 1'b0;
        n_cmp++; if (got.size() !== 101) begin n_err++; $display("FAIL rs_out_size: got %0d expected 101", got.size()); end
        n_cmp++; if (got.size() == 101 && (got[99] !== 8'd99 || got[100] !== 8'hC3)) begin n_err++; $display("FAIL rs_tail: got %h %h expected 63 c3", got[99], got[100]); end
    endtask

    task automatic test_reset_mid_block();
        do_reset();
        data_ready = 1'b0;
        pulse_start();
        send(8'hFE);
        for (int i = 0; i < 5; i++) send(8'hE0 + 8'(i));
        n_cmp++; if (level !== 5'd5) begin n_err++; $display("FAIL rm_level5: got %0d expected 5", level); end
        reset       = 1'b0;
        block_start = 1'b1;
        byte_strobe = 1'b1;
        data_ready  = 1'b1;
        tick();
        reset       = 1'b1;
        block_start = 1'b0;
        byte_strobe = 1'b0;
        data_ready  = 1'b0;
        n_cmp++; if ({data_valid, level} !== 6'd0) begin n_err++; $display("FAIL rm_fifo: got valid %b level %0d expected empty", data_valid, level); end
        n_cmp++; if ({busy, byte_count} !== 11'd0) begin n_err++; $display("FAIL rm_state: got busy %b count %0d expected 0/0", busy, byte_count); end
        n_cmp++; if ({block_done, overflow, token_error} !== 3'b000) begin n_err++; $display("FAIL rm_flags: got %b expected 000", {block_done, overflow, token_error}); end
    endtask

    initial begin
        reset       = 1'b0;
        block_start = 1'b0;
        byte_in     = 8'h00;
        byte_strobe = 1'b0;
        data_ready  = 1'b0;
        test_reset();
        test_normal_block();
        test_backpressure();
        test_full_push_pop();
        test_error_token();
        test_restart();
        test_reset_mid_block();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sd_block_collector.md
SD_BLOCK_COLLECTOR -- requirements
Module: sd_block_collector

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, >=4).
REQ-002 SHALL have parameter BLOCK_BYTES, default 512, data bytes per SD block.
REQ-003 SHALL have port clock  input  1  single clock for all state.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port block_start  input  1  one-cycle pulse: begin collecting one block.
REQ-006 SHALL have port byte_in  input  8  deserialized byte from the SD reader.
REQ-007 SHALL have port byte_strobe  input  1  one-cycle pulse qualifying byte_in.
REQ-008 SHALL have port data_out  output  8  FIFO head byte.
REQ-009 SHALL have port data_valid  output  1  FIFO non-empty.
REQ-010 SHALL have port data_ready  input  1  consumer accepts data_out when data_valid.
REQ-011 SHALL have port level  output  log2(DEPTH)+1  FIFO occupancy.
REQ-012 SHALL have port byte_count  output  10  data bytes received in current block.
REQ-013 SHALL have port block_done  output  1  one-cycle pulse at block completion.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port overflow  output  1  sticky: data byte dropped on full FIFO.
REQ-016 SHALL have port token_error  output  1  sticky: SD error token seen.

Function
REQ-017 SHALL implement states IDLE, HUNT, DATA, CRC, DONE.
REQ-018 IDLE: block_start SHALL move to HUNT, clear byte_count, overflow, token_error; otherwise hold.
REQ-019 HUNT: strobed 0xFE SHALL move to DATA; strobed byte with byte_in[7:4]==0000 SHALL set token_error and move to IDLE; all other strobed bytes (0xFF etc.) SHALL be discarded.
REQ-020 DATA: each strobed byte SHALL be pushed to FIFO and increment byte_count; on the strobe that makes byte_count reach BLOCK_BYTES, SHALL move to CRC.
REQ-021 CRC: exactly two strobed bytes SHALL be discarded (not pushed), then move to DONE.
REQ-022 DONE: block_done SHALL be high for exactly this one cycle; next state IDLE.
REQ-023 byte_strobe outside HUNT/DATA/CRC SHALL be ignored.
REQ-024 block_start in any non-IDLE state SHALL restart at HUNT, clear byte_count and sticky flags, and SHALL NOT flush the FIFO.
REQ-025 FIFO SHALL be first-word-fall-through: byte pushed in cycle N SHALL appear on data_out with data_valid high in cycle N+1.
REQ-026 Pop SHALL occur on any cycle with data_valid && data_ready; data_ready while empty SHALL have no effect.
REQ-027 Simultaneous push and pop SHALL leave level unchanged, including when full (push accepted).
REQ-028 Push when full without pop SHALL drop the byte, set overflow, and still increment byte_count.
REQ-029 Read/write pointers SHALL wrap modulo DEPTH; level SHALL range 0..DEPTH.
REQ-030 byte_count SHALL hold its final value after DONE until next block_start.
REQ-031 All outputs SHALL be registered except data_out (memory at read pointer) and data_valid (level != 0).

Reset
REQ-032 reset low at a clock edge SHALL force IDLE, empty FIFO (pointers and level 0), byte_count 0, block_done 0, busy 0, overflow 0, token_error 0, regardless of current state.
REQ-033 Reset SHALL take priority over block_start, byte_strobe and data_ready in the same cycle.
REQ-034 FIFO storage contents need not be reset.

Verification
REQ-035 Normal block: block_start, strobes 0xFF,0xFF,0xFE, bytes 0x00..0xFF,0x00..0xFF, CRC 0xAA,0x55, data_ready=1 -> 512 bytes out in order, CRC absent, block_done one cycle after second CRC strobe, byte_count=512, overflow=0.
REQ-036 Backpressure: DEPTH=16, data_ready=0 for 20 data bytes -> level=16, overflow=1, bytes 17..20 missing, byte_count=20; data_ready=1 -> first 16 bytes emerge in order.
REQ-037 Full with simultaneous push/pop: level=16, strobe with data_ready=1 -> level stays 16, overflow stays 0, new byte appears last.
REQ-038 Error token: in HUNT strobe 0x05 -> token_error=1, state IDLE, busy=0, FIFO empty, no block_done.
REQ-039 Restart mid-block: after 100 data bytes, block_start -> busy=1, byte_count=0, state HUNT, 100 already-pushed bytes still drain.
REQ-040 Reset mid-block: reset low during DATA with level=5 -> next cycle level=0, data_valid=0, busy=0, byte_count=0, flags 0.
